// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions: FSM state encoding, board default bit period, frame-length helper.
// Latency and backpressure: none (definitions only).
package uart_tx_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // 12 MHz board clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  function automatic int frame_bits(input int parity_en, input int stop_bits);
    return 1 + 8 + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: tick is high while count = 0; reloads CLKS_PER_BIT-1 on load or tick.
// Latency: tick asserts CLKS_PER_BIT-1 cycles after a load; no backpressure.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load || tick) begin
      count <= RELOAD;
    end else begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// Async serial transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits; tx idles high.
// Latency: tx drops on the accepting edge; requests while is_transmitting=1 are dropped, not queued.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       is_transmitting,
  output logic       tx,
  output logic       tx_done
);

  tx_state_t  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       par_q, par_d;
  logic       stop_idx_q, stop_idx_d;
  logic       tx_d, busy_d, done_d;
  logic       load, tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      shreg_q         <= '0;
      bit_idx_q       <= '0;
      par_q           <= 1'b0;
      stop_idx_q      <= 1'b0;
      tx              <= 1'b1;
      is_transmitting <= 1'b0;
      tx_done         <= 1'b0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      bit_idx_q       <= bit_idx_d;
      par_q           <= par_d;
      stop_idx_q      <= stop_idx_d;
      tx              <= tx_d;
      is_transmitting <= busy_d;
      tx_done         <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so tx, busy and done all leave flops.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    par_d      = par_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx;
    busy_d     = is_transmitting;
    done_d     = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (transmit) begin
          shreg_d = tx_byte;
          par_d   = (^tx_byte) ^ 1'(PARITY_ODD);
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d      = shreg_q[0];
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_idx_d = 1'b0;
              state_d    = ST_STOP;
            end
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
